bjt_redirect_ctrl: RTL and testbench
====================================

Name: bjt_redirect_ctrl

Overview:
- Owns the fetch PC and sequences all control-flow redirects for the pipeline.
- Arbitrates between the EX-stage branch/jump result and the ID-stage early jump from the branch-and-jump unit.
- Issues IF/ID and ID/EX flushes.
- Keeps the instruction-fetch valid/ready handshake legal across redirects.

Parameters:
- ADR_BIT, 32: address width; matches the global `ADR_BIT` macro.
- RESET_PC, 0: fetch address after reset.
- INSN_BYTES, 4: PC increment per accepted fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- branch_jump_flag  in  1  EX-stage redirect request: taken branch or jump.
- branch_addr_ex  in  ADR_BIT  EX-stage target.
- id_jump_flag  in  1  ID-stage jump detected.
- branch_addr_id  in  ADR_BIT  ID-stage jump target.
- pipe_stall  in  1  ID/EX frozen this cycle, e.g. hazard or memory stall.
- fetch_ready  in  1  instruction memory accepts the request; data returns exactly 1 cycle after the handshake.
- fetch_valid  out  1  fetch request valid.
- fetch_addr  out  ADR_BIT  fetch address.
- flush_id  out  1  kill the IF/ID register contents this cycle (combinational).
- flush_ex  out  1  kill the ID/EX register contents this cycle (combinational).
- squash_resp  out  1  the fetch response arriving this cycle is wrong-path; discard it.

Behaviour:
- States: BOOT, RUN, DRAIN.
  - Reset: state=BOOT, pc=RESET_PC, pend=0, jmp_mark=0, squash_resp=0.
  - In BOOT: fetch_valid=0, flush_id=0, flush_ex=0. BOOT lasts exactly 1 cycle after rst falls, then RUN.
- Reset mid-operation: rst in any state forces BOOT and the reset values in the next cycle, regardless of other inputs.
- Internal qualifiers:
  - hs = fetch_valid & fetch_ready.
  - hold = fetch_valid & ~fetch_ready registered from the previous cycle.
  - ex_take = branch_jump_flag & ~jmp_mark.
  - id_take = id_jump_flag & ~pipe_stall & ~ex_take & (state==RUN).
- Fetch request:
  - fetch_valid = (state != BOOT) & (~pipe_stall | hold).
  - fetch_addr = pc.
  - Stability rule: once fetch_valid is high without ready, valid and addr hold unchanged until hs.
- RUN:
  - ex_take: flush_id=1, flush_ex=1, target=branch_addr_ex, jmp_mark<=0.
  - Else id_take: flush_id=1, target=branch_addr_id, jmp_mark<=1.
  - EX always beats ID on simultaneous requests; EX holds the older instruction.
  - Redirect with hs or with fetch_valid=0: pc<=target, stay in RUN. If hs occurred, squash_resp<=1 next cycle.
  - Redirect with fetch_valid=1 & ~fetch_ready: pend<=target, go to DRAIN, pc unchanged.
  - No redirect: hs -> pc <= pc + INSN_BYTES, modulo 2^ADR_BIT with wrap and no flag.
- DRAIN:
  - flush_id=1 every cycle; id_jump_flag is ignored.
  - ex_take: flush_ex=1, pend<=branch_addr_ex, jmp_mark<=0.
  - On hs: squash_resp<=1 next cycle, pc<=pend (or branch_addr_ex if ex_take that same cycle), go to RUN.
- jmp_mark (suppresses the EX echo of a jump already redirected in ID):
  - Set on id_take.
  - Cleared on the first later cycle with ~pipe_stall, or on ex_take.
  - A branch_jump_flag while jmp_mark=1 produces no flush and no redirect.
- Targets are used unmodified; no alignment checking.
- squash_resp is a 1-cycle pulse, otherwise 0.

Decomposition:
- Shared global macro file: ADR_BIT, state encodings (CTL_BOOT/CTL_RUN/CTL_DRAIN), INSN_BYTES.
- Single module; no sub-module needed.
- Optional helper: redirect_arb (pure combinational EX/ID priority and target mux) if reuse is wanted.

Test Plan:
- Reset and sequential fetch: rst high 2 cycles, fetch_ready=1, no stall -> fetch_valid low 1 cycle after rst falls, then fetch_addr 0x0, 0x4, 0x8 on consecutive cycles.
- EX redirect: pc=0x10 with hs, branch_jump_flag=1, branch_addr_ex=0x100 -> flush_id=flush_ex=1 same cycle; next cycle squash_resp=1 and fetch_addr=0x100.
- ID jump and EX echo: id_jump_flag=1, branch_addr_id=0x200 -> flush_id=1, flush_ex=0, fetch_addr=0x200 next cycle. Following cycle branch_jump_flag=1 -> no flush; fetch continues 0x204.
- Redirect during a busy fetch: pc=0x10, fetch_ready=0, EX target 0x100 -> state DRAIN, fetch_addr held at 0x10 and flush_id=1 until ready. Cycle after ready: squash_resp=1, then fetch_addr=0x100.
- Simultaneous requests: branch_jump_flag (0x300) and id_jump_flag (0x400) same cycle -> target 0x300, both flushes, jmp_mark stays 0.
- DRAIN overwrite and reset: in DRAIN with pend=0x100, EX target 0x500 -> after hs fetch_addr=0x500. Separately, rst asserted in DRAIN -> next cycle BOOT and fetch_valid=0, then fetch_addr=RESET_PC.

Source files
------------

// File: rtl/bjt_redirect_ctrl_pkg.sv
// Shared constants and controller state encoding for the fetch redirect controller.
package bjt_redirect_ctrl_pkg;

  localparam int unsigned CTL_ADR_BIT    = 32;
  localparam int unsigned CTL_INSN_BYTES = 4;

  typedef enum logic [1:0] {
    CTL_BOOT  = 2'd0,
    CTL_RUN   = 2'd1,
    CTL_DRAIN = 2'd2
  } ctl_state_e;

endpackage

// File: rtl/bjt_redirect_ctrl.sv
// Fetch PC owner: arbitrates EX/ID redirects, issues pipeline flushes and keeps
// the instruction-fetch valid/ready handshake stable across redirects.
module bjt_redirect_ctrl
  import bjt_redirect_ctrl_pkg::*;
#(
  parameter int unsigned          ADR_BIT    = CTL_ADR_BIT,
  parameter logic [ADR_BIT-1:0]   RESET_PC   = '0,
  parameter int unsigned          INSN_BYTES = CTL_INSN_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_jump_flag,
  input  logic [ADR_BIT-1:0] branch_addr_ex,
  input  logic               id_jump_flag,
  input  logic [ADR_BIT-1:0] branch_addr_id,
  input  logic               pipe_stall,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [ADR_BIT-1:0] fetch_addr,
  output logic               flush_id,
  output logic               flush_ex,
  output logic               squash_resp
);

  ctl_state_e         state, state_n;
  logic [ADR_BIT-1:0] pc, pc_n;
  logic [ADR_BIT-1:0] pend, pend_n;
  logic [ADR_BIT-1:0] target;
  logic               jmp_mark, jmp_n;
  logic               hold, hold_n;
  logic               squash_n;
  logic               hs, ex_take, id_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CTL_BOOT;
      pc          <= RESET_PC;
      pend        <= '0;
      jmp_mark    <= 1'b0;
      hold        <= 1'b0;
      squash_resp <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend        <= pend_n;
      jmp_mark    <= jmp_n;
      hold        <= hold_n;
      squash_resp <= squash_n;
    end
  end

  always_comb begin
    ex_take     = branch_jump_flag & ~jmp_mark;
    id_take     = id_jump_flag & ~pipe_stall & ~ex_take & (state == CTL_RUN);
    fetch_valid = (state != CTL_BOOT) & (~pipe_stall | hold);
    fetch_addr  = pc;
    hs          = fetch_valid & fetch_ready;
    target      = ex_take ? branch_addr_ex : branch_addr_id;

    state_n  = state;
    pc_n     = pc;
    pend_n   = pend;
    jmp_n    = jmp_mark;
    hold_n   = fetch_valid & ~fetch_ready;
    squash_n = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;

    // The jump mark only needs to outlive stalls; a set on id_take wins over this clear.
    if (!pipe_stall) jmp_n = 1'b0;

    case (state)
      CTL_BOOT: state_n = CTL_RUN;

      CTL_RUN: begin
        if (ex_take) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
          jmp_n    = 1'b0;
        end else if (id_take) begin
          flush_id = 1'b1;
          jmp_n    = 1'b1;
        end
        if (ex_take || id_take) begin
          // An outstanding request must not change address, so park the target.
          if (fetch_valid && !fetch_ready) begin
            pend_n  = target;
            state_n = CTL_DRAIN;
          end else begin
            pc_n     = target;
            squash_n = hs;
          end
        end else if (hs) begin
          pc_n = pc + ADR_BIT'(INSN_BYTES);
        end
      end

      CTL_DRAIN: begin
        flush_id = 1'b1;
        if (ex_take) begin
          flush_ex = 1'b1;
          pend_n   = branch_addr_ex;
          jmp_n    = 1'b0;
        end
        if (hs) begin
          squash_n = 1'b1;
          pc_n     = ex_take ? branch_addr_ex : pend;
          state_n  = CTL_RUN;
        end
      end

      default: state_n = CTL_BOOT;
    endcase
  end

endmodule

// File: tb/tb_bjt_redirect_ctrl.sv
// Scoreboard bench for bjt_redirect_ctrl: directed test-plan sequences followed by
// random traffic, checked against a target-centric behavioural model.
module tb_bjt_redirect_ctrl;

  typedef struct {
    logic        fv;
    logic [31:0] fa;
    logic        fid;
    logic        fex;
    logic        sq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_jump_flag = 1'b0;
  logic [31:0] branch_addr_ex = '0;
  logic        id_jump_flag = 1'b0;
  logic [31:0] branch_addr_id = '0;
  logic        pipe_stall = 1'b0;
  logic        fetch_ready = 1'b1;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        flush_id;
  logic        flush_ex;
  logic        squash_resp;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model state: a redirect target is either applied at once or held as a
  // pending target until the outstanding fetch is accepted.
  bit          m_boot = 1'b1;
  bit          m_drain = 1'b0;
  bit          m_mark = 1'b0;
  bit          m_hold = 1'b0;
  bit          m_sq = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_pend = '0;

  bjt_redirect_ctrl #(
    .ADR_BIT   (32),
    .RESET_PC  (32'h0),
    .INSN_BYTES(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .branch_jump_flag(branch_jump_flag),
    .branch_addr_ex  (branch_addr_ex),
    .id_jump_flag    (id_jump_flag),
    .branch_addr_id  (branch_addr_id),
    .pipe_stall      (pipe_stall),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .fetch_addr      (fetch_addr),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .squash_resp     (squash_resp)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit bj, input logic [31:0] bex,
                      input bit id, input logic [31:0] bid, input bit st, input bit rd);
    exp_t        e;
    bit          valid, ex, idt, have;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    rst = r; branch_jump_flag = bj; branch_addr_ex = bex;
    id_jump_flag = id; branch_addr_id = bid; pipe_stall = st; fetch_ready = rd;

    valid = !m_boot && (!st || m_hold);
    ex    = bj && !m_mark;
    idt   = !m_boot && !m_drain && id && !st && !ex;
    e.fv  = valid;
    e.fa  = m_pc;
    e.fid = !m_boot && (m_drain || ex || idt);
    e.fex = !m_boot && ex;
    e.sq  = m_sq;
    sb.push_back(e);

    if (r) begin
      m_boot = 1; m_drain = 0; m_mark = 0; m_hold = 0; m_sq = 0; m_pc = '0; m_pend = '0;
    end else if (m_boot) begin
      m_boot = 0;
    end else begin
      m_sq = 0;
      have = 1;
      tgt  = '0;
      if (ex) tgt = bex;
      else if (idt) tgt = bid;
      else if (m_drain) tgt = m_pend;
      else have = 0;
      if (have) begin
        if (valid && rd) begin m_pc = tgt; m_sq = 1; m_drain = 0; end
        else if (valid) begin m_pend = tgt; m_drain = 1; end
        else m_pc = tgt;
      end else if (valid && rd) begin
        m_pc = m_pc + 32'd4;
      end
      if (ex) m_mark = 0;
      else if (idt) m_mark = 1;
      else if (!st) m_mark = 0;
      m_hold = valid && !rd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        if (fetch_valid !== e.fv) begin
          n_bad++; $display("FAIL fetch_valid t=%0t got %b want %b", $time, fetch_valid, e.fv);
        end
        if (fetch_addr !== e.fa) begin
          n_bad++; $display("FAIL fetch_addr t=%0t got %h want %h", $time, fetch_addr, e.fa);
        end
        if (flush_id !== e.fid) begin
          n_bad++; $display("FAIL flush_id t=%0t got %b want %b", $time, flush_id, e.fid);
        end
        if (flush_ex !== e.fex) begin
          n_bad++; $display("FAIL flush_ex t=%0t got %b want %b", $time, flush_ex, e.fex);
        end
        if (squash_resp !== e.sq) begin
          n_bad++; $display("FAIL squash_resp t=%0t got %b want %b", $time, squash_resp, e.sq);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] a, b;
    // reset and sequential fetch up to pc=0x10
    step(1, 0, '0, 0, '0, 0, 1);
    step(1, 0, '0, 0, '0, 0, 1);
    idle(5);
    // EX redirect with handshake
    step(0, 1, 32'h100, 0, '0, 0, 1);
    idle(2);
    // ID jump followed by its EX echo
    step(0, 0, '0, 1, 32'h200, 0, 1);
    step(0, 1, 32'h200, 0, '0, 0, 1);
    idle(2);
    // redirect while fetch busy, drained after two cycles
    step(0, 1, 32'h100, 0, '0, 0, 0);
    step(0, 0, '0, 0, '0, 0, 0);
    step(0, 0, '0, 0, '0, 1, 0);
    step(0, 0, '0, 0, '0, 0, 1);
    idle(2);
    // simultaneous EX and ID requests
    step(0, 1, 32'h300, 1, 32'h400, 0, 1);
    step(0, 1, 32'h304, 0, '0, 0, 1);
    idle(2);
    // DRAIN overwrite by a later EX target
    step(0, 1, 32'h100, 0, '0, 0, 0);
    step(0, 1, 32'h500, 0, '0, 0, 0);
    step(0, 0, '0, 0, '0, 0, 1);
    idle(2);
    // reset while in DRAIN
    step(0, 1, 32'h100, 0, '0, 0, 0);
    step(1, 0, '0, 0, '0, 0, 0);
    idle(3);
    // address wrap
    step(0, 1, 32'hFFFF_FFF8, 0, '0, 0, 1);
    idle(4);
    // ID jump under stall is ignored; stall without hold drops valid
    step(0, 0, '0, 1, 32'h700, 1, 1);
    step(0, 1, 32'h800, 0, '0, 1, 1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      b = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(99) < 1, $urandom_range(99) < 20, a,
           $urandom_range(99) < 20, b, $urandom_range(99) < 25, $urandom_range(99) < 70);
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
